pc_sequencer: RTL and testbench

Fetch-side controller that owns the program counter and decides, every cycle, where the next instruction fetch comes from: sequential, branch, jump or exception vector. It sits between the decode/execute redirect sources, the hazard unit and the instruction memory port. It gates PC advance on stalls and memory readiness, buffers redirects that arrive while the front end is frozen, and issues a one-cycle flush to the fetch/decode pipeline register on every redirect.

---
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and picks the next fetch source each
// cycle (sequential, branch, jump, exception vector). Redirects that arrive
// while the front end cannot advance are parked in a one-entry buffer and
// applied on the next advancing edge. Every applied redirect emits a
// one-cycle flush to the IF/ID register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_BOOT   | first cycle out of reset, no fetch issued
// ST_RUN    | normal fetch, pc advances when unstalled and memory ready
// ST_BUBBLE | cycle right after a redirect, fetch squashed

module pc_sequencer #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        hazard_stall_i,
   input  logic        imem_ready_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        jmp_valid_i,
   input  logic [31:0] jmp_target_i,
   input  logic        exc_valid_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        fetch_valid_o,
   output logic        flush_o,
   output logic        redirect_pending_o
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_BUBBLE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_addr_q, pend_addr_d;
   logic        flush_q, flush_d;
   logic        fetch_valid_q;

   logic        advance;
   logic        new_redirect;
   logic [31:0] new_target;

   assign advance      = (state_q == ST_RUN) && !hazard_stall_i && imem_ready_i;
   assign new_redirect = br_taken_i || jmp_valid_i;
   // Branch wins over a simultaneous jump; targets are forced word aligned.
   assign new_target   = br_taken_i ? {br_target_i[31:2], 2'b00}
                                    : {jmp_target_i[31:2], 2'b00};

   // Next-state: redirect priority exc > branch/jump > pending > sequential.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      flush_d     = 1'b0;

      case (state_q)
         ST_BOOT:   state_d = ST_RUN;
         ST_BUBBLE: if (!hazard_stall_i) state_d = ST_RUN;
         ST_RUN:    state_d = ST_RUN;
         default:   state_d = ST_BOOT;
      endcase

      if (exc_valid_i) begin
         pc_d    = EXC_VECTOR;
         flush_d = 1'b1;
         pend_d  = 1'b0;
         state_d = ST_BUBBLE;
      end else if (new_redirect && advance) begin
         // A fresh redirect supersedes anything still parked.
         pc_d    = new_target;
         flush_d = 1'b1;
         pend_d  = 1'b0;
         state_d = ST_BUBBLE;
      end else if (new_redirect) begin
         pend_d      = 1'b1;
         pend_addr_d = new_target;
      end else if (advance && pend_q) begin
         pc_d    = pend_addr_q;
         flush_d = 1'b1;
         pend_d  = 1'b0;
         state_d = ST_BUBBLE;
      end else if (advance) begin
         pc_d = pc_q + 32'd4;
      end
   end

   // State and output registers; reset restarts the sequence from BOOT.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_ADDR;
         pend_q        <= 1'b0;
         pend_addr_q   <= 32'd0;
         flush_q       <= 1'b0;
         fetch_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_q        <= pend_d;
         pend_addr_q   <= pend_addr_d;
         flush_q       <= flush_d;
         fetch_valid_q <= (state_d == ST_RUN);
      end
   end

   assign pc_o               = pc_q;
   assign pc_plus4_o         = pc_q + 32'd4;
   assign fetch_valid_o      = fetch_valid_q;
   assign flush_o            = flush_q;
   assign redirect_pending_o = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random traffic.
// The driver computes the expected post-edge outputs from a small
// behavioural model and queues them; an independent monitor pops and
// compares after every rising edge.

module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0, ready = 1'b1;
   logic        br = 1'b0, jmp = 1'b0, exc = 1'b0;
   logic [31:0] bt = '0, jt = '0;
   logic [31:0] pc, pc4;
   logic        fv, fl, rp;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic        fv;
      logic        fl;
      logic        rp;
   } exp_t;
   exp_t exp_q[$];

   // Model: phase 0 = just out of reset, 1 = fetching, 2 = squashed cycle.
   int          m_phase;
   logic [31:0] m_pc;
   logic        m_flush;
   bit          m_has_pend;
   logic [31:0] m_pend;

   pc_sequencer dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .hazard_stall_i(stall), .imem_ready_i(ready),
      .br_taken_i(br), .br_target_i(bt),
      .jmp_valid_i(jmp), .jmp_target_i(jt),
      .exc_valid_i(exc),
      .pc_o(pc), .pc_plus4_o(pc4), .fetch_valid_o(fv),
      .flush_o(fl), .redirect_pending_o(rp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: compare every queued expectation just after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("mon_pc", pc, e.pc);
         chk("mon_pc_plus4", pc4, e.pc + 32'd4);
         chk("mon_fetch_valid", {31'd0, fv}, {31'd0, e.fv});
         chk("mon_flush", {31'd0, fl}, {31'd0, e.fl});
         chk("mon_pending", {31'd0, rp}, {31'd0, e.rp});
      end
   end

   function automatic void model_reset();
      m_phase = 0; m_pc = RST_PC; m_flush = 1'b0;
      m_has_pend = 0; m_pend = '0;
   endfunction

   function automatic void model_edge(bit s, bit r, bit b, logic [31:0] btv,
                                      bit j, logic [31:0] jtv, bit e);
      bit          can_go;
      bit          redirect;
      logic [31:0] dest;
      can_go   = (m_phase == 1) && !s && r;
      redirect = b || j;
      dest     = b ? (btv & 32'hFFFF_FFFC) : (jtv & 32'hFFFF_FFFC);
      m_flush  = 1'b0;
      if (e) begin
         m_pc = EXC_PC; m_flush = 1'b1; m_has_pend = 0; m_phase = 2;
         return;
      end
      if (redirect && can_go) begin
         m_pc = dest; m_flush = 1'b1; m_has_pend = 0; m_phase = 2;
         return;
      end
      if (!redirect && can_go && m_has_pend) begin
         m_pc = m_pend; m_flush = 1'b1; m_has_pend = 0; m_phase = 2;
         return;
      end
      if (redirect) begin
         m_has_pend = 1; m_pend = dest;
      end else if (can_go) begin
         m_pc = m_pc + 32'd4;
      end
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 2 && !s) m_phase = 1;
   endfunction

   task automatic step(input bit s, input bit r, input bit b, input logic [31:0] btv,
                       input bit j, input logic [31:0] jtv, input bit e);
      exp_t x;
      @(negedge clk);
      stall = s; ready = r; br = b; bt = btv; jmp = j; jt = jtv; exc = e;
      model_edge(s, r, b, btv, j, jtv, e);
      x.pc = m_pc; x.fv = (m_phase == 1); x.fl = m_flush; x.rp = m_has_pend;
      exp_q.push_back(x);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, '0, 0, '0, 0);
   endtask

   // Async reset asserted between edges; outputs must clear without a clock.
   task automatic do_reset();
      #2;
      stall = 0; ready = 1; br = 0; jmp = 0; exc = 0;
      reset_n = 1'b0;
      #1;
      chk("rst_pc", pc, RST_PC);
      chk("rst_fetch_valid", {31'd0, fv}, 32'd0);
      chk("rst_flush", {31'd0, fl}, 32'd0);
      chk("rst_pending", {31'd0, rp}, 32'd0);
      exp_q.delete();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      do_reset();

      // Boot and sequential fetch.
      step(0, 1, 0, '0, 0, '0, 0);
      #2 chk("boot_pc", pc, 32'h3000);
      chk("boot_fv", {31'd0, fv}, 32'd1);
      idle(2);
      #2 chk("seq_pc", pc, 32'h3008);
      idle(2);
      #2 chk("pre_branch_pc", pc, 32'h3010);

      // Taken branch with unaligned target.
      step(0, 1, 1, 32'h3103, 0, '0, 0);
      #2 chk("br_pc", pc, 32'h3100);
      chk("br_flush", {31'd0, fl}, 32'd1);
      chk("br_bubble_fv", {31'd0, fv}, 32'd0);
      idle(2);
      #2 chk("br_seq_pc", pc, 32'h3104);

      // Jump during a 3-cycle stall is buffered.
      step(1, 1, 0, '0, 1, 32'h3200, 0);
      step(1, 1, 0, '0, 0, '0, 0);
      step(1, 1, 0, '0, 0, '0, 0);
      #2 chk("stall_hold_pc", pc, 32'h3104);
      chk("stall_pending", {31'd0, rp}, 32'd1);
      step(0, 1, 0, '0, 0, '0, 0);
      #2 chk("pend_apply_pc", pc, 32'h3200);
      chk("pend_apply_flush", {31'd0, fl}, 32'd1);
      chk("pend_cleared", {31'd0, rp}, 32'd0);

      // Exception overrides a pending branch while stalled and not ready.
      idle(1);
      step(1, 0, 1, 32'h3300, 0, '0, 0);
      step(1, 0, 0, '0, 0, '0, 1);
      #2 chk("exc_pc", pc, 32'h4180);
      chk("exc_pending", {31'd0, rp}, 32'd0);
      chk("exc_flush", {31'd0, fl}, 32'd1);
      // Second exception while in the bubble flushes again.
      step(0, 1, 0, '0, 0, '0, 1);
      #2 chk("exc_bubble_flush", {31'd0, fl}, 32'd1);

      // Wrap at the top of the address space.
      idle(1);
      step(0, 1, 0, '0, 1, 32'hFFFF_FFFF, 0);
      #2 chk("wrap_jump_pc", pc, 32'hFFFF_FFFC);
      idle(2);
      #2 chk("wrap_pc", pc, 32'h0000_0000);

      // Reset in the middle of a stall with a redirect parked.
      step(1, 1, 1, 32'h5000, 0, '0, 0);
      do_reset();
      idle(2);
      #2 chk("post_reset_pc", pc, 32'h3004);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bit s, r, b, j, e;
         logic [31:0] btv, jtv;
         s   = ($urandom_range(0, 9) < 3);
         r   = ($urandom_range(0, 9) < 8);
         b   = ($urandom_range(0, 9) < 2);
         j   = ($urandom_range(0, 9) < 2);
         e   = ($urandom_range(0, 49) == 0);
         btv = $urandom();
         jtv = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | {28'd0, 4'($urandom())}) : $urandom();
         step(s, r, b, btv, j, jtv, e);
         if ($urandom_range(0, 299) == 0) do_reset();
      end

      @(posedge clk);
      #3;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
